// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the Flappy Bird game sequencer and its neighbours
// (VGA timing generator, button debouncer, pixel renderer, score display).
interface flappy_game_ctrl_if;
  logic        vsync;
  logic        flap;
  logic        collide;
  logic        pipe_passed;
  logic        frame_tick;
  logic [1:0]  state;
  logic [8:0]  bird_y;
  logic        scroll_en;
  logic [15:0] score;
  logic        game_over;

  // Environment side: drives sync, button and renderer feedback.
  modport master (
    output vsync, flap, collide, pipe_passed,
    input  frame_tick, state, bird_y, scroll_en, score, game_over
  );

  // Game sequencer side.
  modport slave (
    input  vsync, flap, collide, pipe_passed,
    output frame_tick, state, bird_y, scroll_en, score, game_over
  );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Frame-level game sequencer: derives a frame tick from vsync, runs the game
// FSM and bird vertical physics once per frame, and keeps a BCD score.
module flappy_game_ctrl #(
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned BIRD_H       = 16,
  parameter int unsigned BIRD_Y0      = 240,
  parameter int unsigned GRAVITY      = 1,
  parameter int unsigned FLAP_VEL     = 8,
  parameter int unsigned VMAX         = 12,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input logic               i_clk,
  input logic               i_clr,
  flappy_game_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StDying = 2'd2,
    StOver  = 2'd3
  } state_e;

  localparam int unsigned        CntW     = $clog2(DEATH_FRAMES + 1);
  localparam logic [CntW-1:0]    CntLast  = CntW'(DEATH_FRAMES - 1);
  localparam logic [8:0]         FloorY   = 9'(SCREEN_H - BIRD_H);
  localparam logic signed [10:0] FloorS   = 11'(SCREEN_H - BIRD_H);
  localparam logic [8:0]         StartY   = 9'(BIRD_Y0);
  localparam logic [8:0]         LaunchY  = 9'(BIRD_Y0 - FLAP_VEL);
  localparam logic signed [5:0]  FlapVelN = 6'(0 - FLAP_VEL);
  localparam logic signed [6:0]  GravS    = 7'(GRAVITY);
  localparam logic signed [6:0]  VmaxS    = 7'(VMAX);

  logic r_vs_s1, r_vs_s2, r_vs_s3, r_frame_tick;
  logic r_fl_s1, r_fl_s2, r_fl_s3, r_flap_pending;

  state_e             r_state;
  logic [8:0]         r_bird_y;
  logic signed [5:0]  r_vel;
  logic [CntW-1:0]    r_cnt;
  logic [15:0]        r_score;
  logic               r_scroll_en;
  logic               r_game_over;

  logic               w_vs_fall;
  logic               w_fl_rise;
  logic signed [6:0]  w_vel_sum;
  logic signed [5:0]  w_vel_grav;
  logic signed [5:0]  w_vel_step;
  logic signed [10:0] w_y_sum;
  logic [8:0]         w_y_phys;
  logic signed [5:0]  w_vel_phys;
  logic               w_floor_hit;

  // Ripple BCD increment; callers keep the value below 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_vs_fall = r_vs_s3 & ~r_vs_s2;
  assign w_fl_rise = r_fl_s2 & ~r_fl_s3;

  // Synchronise vsync and register its falling edge as the frame tick.
  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_vs_s1      <= 1'b1;
      r_vs_s2      <= 1'b1;
      r_vs_s3      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_vs_s1      <= io_bus.vsync;
      r_vs_s2      <= r_vs_s1;
      r_vs_s3      <= r_vs_s2;
      r_frame_tick <= w_vs_fall;
    end
  end

  // Synchronise the button and latch one flap request per frame.
  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_fl_s1        <= 1'b1;
      r_fl_s2        <= 1'b1;
      r_fl_s3        <= 1'b1;
      r_flap_pending <= 1'b0;
    end else begin
      r_fl_s1 <= io_bus.flap;
      r_fl_s2 <= r_fl_s1;
      r_fl_s3 <= r_fl_s2;
      if (r_frame_tick) begin
        r_flap_pending <= 1'b0;
      end else if (w_fl_rise) begin
        r_flap_pending <= 1'b1;
      end
    end
  end

  // One physics step: new velocity, new row, clamp at ceiling and floor.
  always_comb begin
    w_vel_sum   = $signed({r_vel[5], r_vel}) + GravS;
    w_vel_grav  = (w_vel_sum > VmaxS) ? VmaxS[5:0] : w_vel_sum[5:0];
    w_vel_step  = (r_flap_pending && (r_state == StPlay)) ? FlapVelN : w_vel_grav;
    w_y_sum     = $signed({2'b00, r_bird_y}) + $signed({{5{w_vel_step[5]}}, w_vel_step});
    w_y_phys    = w_y_sum[8:0];
    w_vel_phys  = w_vel_step;
    w_floor_hit = 1'b0;
    if (w_y_sum < 11'sd0) begin
      w_y_phys   = '0;
      w_vel_phys = '0;
    end else if (w_y_sum >= FloorS) begin
      w_y_phys    = FloorY;
      w_floor_hit = 1'b1;
    end
  end

  // Game FSM advanced on frame ticks; score follows pipe pulses at clock rate.
  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_state     <= StIdle;
      r_bird_y    <= StartY;
      r_vel       <= '0;
      r_cnt       <= '0;
      r_score     <= '0;
      r_scroll_en <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      if (io_bus.pipe_passed && (r_state == StPlay) && (r_score != 16'h9999)) begin
        r_score <= bcd_inc(r_score);
      end
      if (r_frame_tick) begin
        unique case (r_state)
          StIdle: begin
            if (r_flap_pending) begin
              r_state     <= StPlay;
              r_score     <= '0;
              r_vel       <= FlapVelN;
              r_bird_y    <= LaunchY;
              r_scroll_en <= 1'b1;
            end
          end
          StPlay: begin
            if (io_bus.collide) begin
              // Collision freezes the bird for this tick and drops any pending flap.
              r_state     <= StDying;
              r_cnt       <= '0;
              r_scroll_en <= 1'b0;
            end else begin
              r_bird_y <= w_y_phys;
              r_vel    <= w_vel_phys;
              if (w_floor_hit) begin
                r_state     <= StDying;
                r_cnt       <= '0;
                r_scroll_en <= 1'b0;
              end
            end
          end
          StDying: begin
            r_bird_y <= w_y_phys;
            r_vel    <= w_vel_phys;
            if ((r_cnt == CntLast) || w_floor_hit) begin
              r_state     <= StOver;
              r_game_over <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CntW'(1);
            end
          end
          StOver: begin
            if (r_flap_pending) begin
              r_state     <= StIdle;
              r_bird_y    <= StartY;
              r_vel       <= '0;
              r_game_over <= 1'b0;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign io_bus.frame_tick = r_frame_tick;
  assign io_bus.state      = r_state;
  assign io_bus.bird_y     = r_bird_y;
  assign io_bus.scroll_en  = r_scroll_en;
  assign io_bus.score      = r_score;
  assign io_bus.game_over  = r_game_over;

endmodule
